// File: rtl/shift_pkg.sv
// Shared definitions for the RV64I shift execute stage: shift codes, opcode/funct
// constants, FSM states and the combinational shift-instruction decoder.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LEFT = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10
    } shift_code_e;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        DONE
    } state_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP32     = 7'b0111011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_ALT  = 6'b010000;

    typedef struct packed {
        logic        legal;
        logic        is_w;
        shift_code_e code;
        logic [5:0]  n;
    } dec_t;

    // Illegal encodings collapse to a left shift by zero so the datapath stays inert.
    function automatic dec_t decode_shift(input logic [31:0] instr, input logic [5:0] rs2_lo);
        dec_t       d;
        logic       base;
        logic       alt;
        logic [2:0] f3;
        d.legal = 1'b0;
        d.is_w  = 1'b0;
        d.code  = SH_LEFT;
        d.n     = 6'd0;
        base    = 1'b0;
        alt     = 1'b0;
        f3      = instr[14:12];
        case (instr[6:0])
            OP_IMM: begin
                base = (instr[31:26] == F6_BASE);
                alt  = (instr[31:26] == F6_ALT);
                d.n  = instr[25:20];
            end
            OP: begin
                base = (instr[31:25] == F7_BASE);
                alt  = (instr[31:25] == F7_ALT);
                d.n  = rs2_lo;
            end
            OP_IMM32: begin
                base   = (instr[31:25] == F7_BASE);
                alt    = (instr[31:25] == F7_ALT);
                d.n    = {1'b0, instr[24:20]};
                d.is_w = 1'b1;
            end
            OP32: begin
                base   = (instr[31:25] == F7_BASE);
                alt    = (instr[31:25] == F7_ALT);
                d.n    = {1'b0, rs2_lo[4:0]};
                d.is_w = 1'b1;
            end
            default: begin
                base = 1'b0;
                alt  = 1'b0;
            end
        endcase
        if (f3 == F3_SLL && base) begin
            d.legal = 1'b1;
            d.code  = SH_LEFT;
        end else if (f3 == F3_SR && base) begin
            d.legal = 1'b1;
            d.code  = SH_SRL;
        end else if (f3 == F3_SR && alt) begin
            d.legal = 1'b1;
            d.code  = SH_SRA;
        end
        if (!d.legal) begin
            d.code = SH_LEFT;
            d.n    = 6'd0;
            d.is_w = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/Deslocamento.sv
// Existing 64-bit barrel shifter: 00 left, 01 logical right, 10 arithmetic right.
module Deslocamento (
    input  logic [1:0]  Shift,
    input  logic [63:0] Entrada,
    input  logic [5:0]  N,
    output logic [63:0] Saida
);

    always_comb begin
        case (Shift)
            2'b00:   Saida = Entrada << N;
            2'b01:   Saida = Entrada >> N;
            2'b10:   Saida = $signed(Entrada) >>> N;
            default: Saida = Entrada;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Four-state execute stage for RV64I shifts: latch, decode, shift, then deliver a
// one-cycle write-back pulse to the register file.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SHW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [4:0]      rd_addr,
    output logic            rd_we,
    output logic [XLEN-1:0] result
);

    state_e          r_state;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rs1;
    logic [SHW-1:0]  r_rs2_lo;
    shift_code_e     r_code;
    logic [SHW-1:0]  r_n;
    logic [XLEN-1:0] r_in;
    logic            r_is_w;
    logic            r_legal;
    logic            r_busy;
    logic            r_done;
    logic            r_illegal;
    logic            r_rd_we;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_result;

    dec_t            w_dec;
    logic [XLEN-1:0] w_in;
    logic [XLEN-1:0] w_saida;
    logic [XLEN-1:0] w_res;

    assign w_dec = decode_shift(r_instr, r_rs2_lo);

    // W-form right shifts see only the low word, extended to match the shift kind.
    always_comb begin
        w_in = r_rs1;
        if (w_dec.is_w && w_dec.code == SH_SRL) begin
            w_in = {{(XLEN-32){1'b0}}, r_rs1[31:0]};
        end else if (w_dec.is_w && w_dec.code == SH_SRA) begin
            w_in = {{(XLEN-32){r_rs1[31]}}, r_rs1[31:0]};
        end
    end

    Deslocamento u_shifter (
        .Shift   (r_code),
        .Entrada (r_in),
        .N       (r_n),
        .Saida   (w_saida)
    );

    always_comb begin
        w_res = w_saida;
        if (!r_legal) begin
            w_res = '0;
        end else if (r_is_w) begin
            w_res = {{(XLEN-32){w_saida[31]}}, w_saida[31:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_instr   <= '0;
            r_rs1     <= '0;
            r_rs2_lo  <= '0;
            r_code    <= SH_LEFT;
            r_n       <= '0;
            r_in      <= '0;
            r_is_w    <= 1'b0;
            r_legal   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_result  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_rd_we   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_instr  <= instr;
                        r_rs1    <= rs1_val;
                        r_rs2_lo <= rs2_val[SHW-1:0];
                        r_busy   <= 1'b1;
                        r_state  <= DECODE;
                    end
                end
                DECODE: begin
                    r_code  <= w_dec.code;
                    r_n     <= w_dec.n;
                    r_in    <= w_dec.legal ? w_in : '0;
                    r_is_w  <= w_dec.is_w;
                    r_legal <= w_dec.legal;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result <= w_res;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done    <= 1'b1;
                    r_illegal <= !r_legal;
                    r_rd_we   <= r_legal && (r_instr[11:7] != 5'd0);
                    r_rd_addr <= r_instr[11:7];
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign rd_addr = r_rd_addr;
    assign rd_we   = r_rd_we;
    assign result  = r_result;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: directed cases plus random shifts checked
// against an ISA-level reference model.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instr;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [63:0] result;

    shift_exec_stage dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .instr   (instr),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .rd_addr (rd_addr),
        .rd_we   (rd_we),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ill;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] res;
        int          cyc;
        logic [31:0] ins;
    } exp_t;

    // ISA encodings: SLLI SRLI SRAI, SLL SRL SRA, SLLIW SRLIW SRAIW, SLLW SRLW SRAW
    localparam logic [31:0] MATCH [12] = '{
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00001033, 32'h00005033, 32'h40005033,
        32'h0000101B, 32'h0000501B, 32'h4000501B,
        32'h0000103B, 32'h0000503B, 32'h4000503B
    };

    exp_t q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        int          hit;
        logic [31:0] mask;
        logic [31:0] lo;
        logic [31:0] r32;
        int          amt;
        int          kind;
        logic        w;
        logic        imm;
        hit = -1;
        for (int i = 0; i < 12; i++) begin
            mask = (i < 3) ? 32'hFC00707F : 32'hFE00707F;
            if ((ins & mask) == MATCH[i]) hit = i;
        end
        e.rd  = ins[11:7];
        e.ins = ins;
        e.cyc = 0;
        if (hit < 0) begin
            e.ill = 1'b1;
            e.we  = 1'b0;
            e.res = 64'd0;
        end else begin
            kind = hit % 3;
            w    = (hit >= 6);
            imm  = ((hit / 3) % 2) == 0;
            if (w) amt = imm ? int'(ins[24:20]) : int'(b[4:0]);
            else   amt = imm ? int'(ins[25:20]) : int'(b[5:0]);
            if (w) begin
                lo = a[31:0];
                case (kind)
                    0:       r32 = lo << amt;
                    1:       r32 = lo >> amt;
                    default: r32 = $signed(lo) >>> amt;
                endcase
                e.res = {{32{r32[31]}}, r32};
            end else begin
                case (kind)
                    0:       e.res = a << amt;
                    1:       e.res = a >> amt;
                    default: e.res = $signed(a) >>> amt;
                endcase
            end
            e.ill = 1'b0;
            e.we  = (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    // Called on a falling edge; leaves one falling edge later with start released.
    task automatic issue_e(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b, input exp_t e);
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_wait: busy stuck at %0d, required 0", busy);
        end
        instr   = ins;
        rs1_val = a;
        rs2_val = b;
        start   = 1'b1;
        e.cyc   = cyc + 4;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_m(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        issue_e(ins, a, b, model(ins, a, b));
    endtask

    task automatic issue_k(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] res, input logic ill, input logic we);
        exp_t e;
        e.ill = ill;
        e.we  = we;
        e.rd  = ins[11:7];
        e.res = res;
        e.cyc = 0;
        e.ins = ins;
        issue_e(ins, a, b, e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 result=%h, required no pending operation", result);
            end else begin
                me = q.pop_front();
                $display("txn instr=%h rd=%0d ill=%0d we=%0d result=%h", me.ins, rd_addr, illegal, rd_we, result);
                chk("latency_cycle", 64'(cyc), 64'(me.cyc));
                chk("illegal", 64'(illegal), 64'(me.ill));
                chk("rd_we", 64'(rd_we), 64'(me.we));
                chk("rd_addr", 64'(rd_addr), 64'(me.rd));
                chk("result", result, me.res);
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [63:0] a;
        logic [63:0] b;
        int          i;
        reset   = 1'b1;
        start   = 1'b0;
        instr   = '0;
        rs1_val = '0;
        rs2_val = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rd_we", 64'(rd_we), 64'd0);
        chk("reset_result", result, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue_k(32'h00209293, 64'd4, 64'd0, 64'd16, 1'b0, 1'b1);
        issue_k(32'h40815193, 64'hFFFFFFFFFFFFFF00, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
        issue_k(32'h00115193, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'h7FFFFFFFFFFFFFFE, 1'b0, 1'b1);
        issue_k(32'h4020D23B, 64'h0000000080000000, 64'h24, 64'hFFFFFFFFF8000000, 1'b0, 1'b1);
        issue_k(32'h0020D23B, 64'h0000000080000000, 64'h24, 64'h0000000008000000, 1'b0, 1'b1);
        issue_k(32'h0210929B, 64'h123456789ABCDEF0, 64'd5, 64'd0, 1'b1, 1'b0);
        issue_k(32'h00108093, 64'h123456789ABCDEF0, 64'd5, 64'd0, 1'b1, 1'b0);
        issue_k(32'h41F0D09B, 64'h0000000080000000, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
        issue_k(32'h00009093, 64'h123456789ABCDEF0, 64'd0, 64'h123456789ABCDEF0, 1'b0, 1'b1);
        issue_k(32'h03F0D093, 64'h8000000000000000, 64'd0, 64'd1, 1'b0, 1'b1);
        issue_k(32'h00209033, 64'd1, 64'd63, 64'h8000000000000000, 1'b0, 1'b0);

        // A start while busy must not produce a second completion.
        start   = 1'b1;
        instr   = 32'h00108093;
        rs1_val = 64'd7;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue_k(32'h00209293, 64'd4, 64'd0, 64'd16, 1'b0, 1'b1);
        drain();

        // Abort an operation while it sits in EXEC.
        issue_k(32'h00309293, 64'd1, 64'd0, 64'd8, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_rd_addr", 64'(rd_addr), 64'd0);
        chk("abort_rd_we", 64'(rd_we), 64'd0);
        void'(q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue_k(32'h4020D23B, 64'h0000000080000000, 64'h24, 64'hFFFFFFFFF8000000, 1'b0, 1'b1);
        drain();

        for (i = 0; i < 200; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) a = 64'h8000000000000000;
            if ($urandom_range(0, 7) == 0) ins = $urandom();
            else begin
                int k;
                k   = $urandom_range(0, 11);
                ins = MATCH[k] | (32'($urandom_range(0, 31)) << 7) | (32'($urandom_range(0, 31)) << 15);
                if (k < 3)             ins = ins | (32'($urandom_range(0, 63)) << 20);
                else                   ins = ins | (32'($urandom_range(0, 31)) << 20);
                if (k >= 6 && k < 9 && $urandom_range(0, 7) == 0) ins = ins | 32'h02000000;
            end
            issue_m(ins, a, b);
        end
        drain();

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
